// File: rtl/pow_root_calc_if.sv
// Start/busy handshake and operand/result bus of the pow_root_calc unit.
// W and EXP must match the attached pow_root_calc instance.
interface pow_root_calc_if #(
  parameter int W   = 8,
  parameter int EXP = 3
);
  localparam int YW = W * EXP + 1;

  logic [W-1:0]  a_bi;
  logic [W-1:0]  b_bi;
  logic          mode_i;
  logic          start_i;
  logic          busy_o;
  logic          valid_o;
  logic [YW-1:0] y_bo;

  modport master (
    output a_bi, b_bi, mode_i, start_i,
    input  busy_o, valid_o, y_bo
  );

  modport slave (
    input  a_bi, b_bi, mode_i, start_i,
    output busy_o, valid_o, y_bo
  );
endinterface

// File: rtl/pow_root_calc.sv
// Sequential y = a^EXP +/- floor(sqrt(b)) unit: a shift-add power engine and
// a bit-serial square-root engine run side by side, then one combine cycle.
module pow_root_calc #(
  parameter int W   = 8,
  parameter int EXP = 3
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  pow_root_calc_if.slave bus
);
  localparam int YW  = W * EXP + 1;
  localparam int HW  = W / 2;
  localparam int RMW = HW + 3;
  localparam int MCW = $clog2(EXP + 1);
  localparam int BCW = $clog2(W);
  localparam int RCW = $clog2(HW + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic           mode_q, mode_d;
  logic [YW-1:0]  acc_q, acc_d;
  logic [YW-1:0]  prod_q, prod_d;
  logic [YW-1:0]  mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
  logic [MCW-1:0] mul_cnt_q, mul_cnt_d;
  logic [W-1:0]   rad_q, rad_d;
  logic [RMW-1:0] rem_q, rem_d;
  logic [HW-1:0]  root_q, root_d;
  logic [RCW-1:0] root_cnt_q, root_cnt_d;
  logic [YW-1:0]  y_q, y_d;
  logic           valid_q, valid_d;
  logic           busy_q, busy_d;

  logic [YW-1:0]  prod_sum;
  logic [RMW-1:0] rem_sh;
  logic [RMW-1:0] trial;
  logic [YW-1:0]  root_ext;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    mode_d     = mode_q;
    acc_d      = acc_q;
    prod_d     = prod_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    bit_cnt_d  = bit_cnt_q;
    mul_cnt_d  = mul_cnt_q;
    rad_d      = rad_q;
    rem_d      = rem_q;
    root_d     = root_q;
    root_cnt_d = root_cnt_q;
    y_d        = y_q;
    valid_d    = 1'b0;
    prod_sum   = prod_q;
    rem_sh     = '0;
    trial      = '0;
    root_ext   = YW'(root_q);

    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d    = CALC;
          a_d        = bus.a_bi;
          mode_d     = bus.mode_i;
          acc_d      = YW'(bus.a_bi);
          prod_d     = '0;
          mcand_d    = YW'(bus.a_bi);
          mplier_d   = bus.a_bi;
          bit_cnt_d  = '0;
          mul_cnt_d  = MCW'(EXP - 1);
          rad_d      = bus.b_bi;
          rem_d      = '0;
          root_d     = '0;
          root_cnt_d = '0;
        end
      end

      CALC: begin
        // One shift-add step of acc * a; the last step of a multiply
        // promotes the product to acc and rearms for the next one.
        if (mul_cnt_q != '0) begin
          prod_sum = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
          if (bit_cnt_q == BCW'(W - 1)) begin
            acc_d     = prod_sum;
            prod_d    = '0;
            mcand_d   = prod_sum;
            mplier_d  = a_q;
            bit_cnt_d = '0;
            mul_cnt_d = mul_cnt_q - MCW'(1);
          end else begin
            prod_d    = prod_sum;
            mcand_d   = mcand_q << 1;
            mplier_d  = mplier_q >> 1;
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end

        // Restoring square root: bring down two radicand bits per cycle.
        if (root_cnt_q != RCW'(HW)) begin
          rem_sh = {rem_q[RMW-3:0], rad_q[W-1 -: 2]};
          trial  = RMW'({root_q, 2'b01});
          if (rem_sh >= trial) begin
            rem_d  = rem_sh - trial;
            root_d = HW'({root_q, 1'b1});
          end else begin
            rem_d  = rem_sh;
            root_d = HW'({root_q, 1'b0});
          end
          rad_d      = rad_q << 2;
          root_cnt_d = root_cnt_q + RCW'(1);
        end

        // Look at the post-edge counters so DONE is entered on the last work edge.
        if ((mul_cnt_d == '0) && (root_cnt_d == RCW'(HW))) begin
          state_d = DONE;
        end
      end

      DONE: begin
        if (mode_q) begin
          y_d = (acc_q >= root_ext) ? (acc_q - root_ext) : '0;
        end else begin
          y_d = acc_q + root_ext;
        end
        valid_d = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      a_q        <= '0;
      mode_q     <= 1'b0;
      acc_q      <= '0;
      prod_q     <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      bit_cnt_q  <= '0;
      mul_cnt_q  <= '0;
      rad_q      <= '0;
      rem_q      <= '0;
      root_q     <= '0;
      root_cnt_q <= '0;
      y_q        <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      mode_q     <= mode_d;
      acc_q      <= acc_d;
      prod_q     <= prod_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      bit_cnt_q  <= bit_cnt_d;
      mul_cnt_q  <= mul_cnt_d;
      rad_q      <= rad_d;
      rem_q      <= rem_d;
      root_q     <= root_d;
      root_cnt_q <= root_cnt_d;
      y_q        <= y_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.busy_o  = busy_q;
  assign bus.valid_o = valid_q;
  assign bus.y_bo    = y_q;
endmodule
